// File: rtl/nabp_state_ctrl_pkg.sv
// Shared types and helpers for the multi-bank NABP state controller.
package nabp_state_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FILLED = 2'd2,
        SHIFT  = 2'd3
    } bank_state_e;

    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned ptr_wrap(
        input int unsigned p,
        input int unsigned n
    );
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/nabp_multi_bank_state_control_bank_fsm.sv
// One shifter bank: IDLE->FILL->FILLED->SHIFT state, config latches, kicks.
// Defining NABP_SIM reports illegal state encodings during simulation.
module nabp_bank_fsm
    import nabp_state_ctrl_pkg::*;
#(
    parameter int SH_ACCU_W = 16,
    parameter int MP_INIT_W = 16,
    parameter int MP_BASE_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc_i,
    input  logic [SH_ACCU_W-1:0] sh_base_i,
    input  logic [MP_INIT_W-1:0] mp_init_i,
    input  logic [MP_BASE_W-1:0] mp_base_i,
    input  logic                 fill_done_i,
    input  logic                 swap_i,
    input  logic                 shift_done_i,
    output bank_state_e          state_o,
    output logic                 fill_kick_o,
    output logic                 shift_kick_o,
    output logic [SH_ACCU_W-1:0] sh_base_o,
    output logic [MP_INIT_W-1:0] mp_init_o,
    output logic [MP_BASE_W-1:0] mp_base_o
);

    bank_state_e          state_q, state_d;
    logic                 fill_kick_q, fill_kick_d;
    logic                 shift_kick_q, shift_kick_d;
    logic [SH_ACCU_W-1:0] sh_base_q;
    logic [MP_INIT_W-1:0] mp_init_q;
    logic [MP_BASE_W-1:0] mp_base_q;

    always_comb begin
        state_d      = state_q;
        fill_kick_d  = 1'b0;
        shift_kick_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (alloc_i) begin
                    state_d     = FILL;
                    fill_kick_d = 1'b1;
                end
            end
            FILL: begin
                if (fill_done_i) state_d = FILLED;
            end
            FILLED: begin
                if (swap_i) begin
                    state_d      = SHIFT;
                    shift_kick_d = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_done_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
`ifdef NABP_SIM
                $display("ERROR nabp_bank_fsm: illegal state %0d", state_q);
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fill_kick_q  <= 1'b0;
            shift_kick_q <= 1'b0;
            sh_base_q    <= '0;
            mp_init_q    <= '0;
            mp_base_q    <= '0;
        end else begin
            state_q      <= state_d;
            fill_kick_q  <= fill_kick_d;
            shift_kick_q <= shift_kick_d;
            if (fill_kick_d) begin
                sh_base_q <= sh_base_i;
                mp_init_q <= mp_init_i;
                mp_base_q <= mp_base_i;
            end
        end
    end

    assign state_o      = state_q;
    assign fill_kick_o  = fill_kick_q;
    assign shift_kick_o = shift_kick_q;
    assign sh_base_o    = sh_base_q;
    assign mp_init_o    = mp_init_q;
    assign mp_base_o    = mp_base_q;

endmodule

// File: rtl/nabp_multi_bank_state_control.sv
// Multi-bank NABP state controller: round-robin fill/shift across banks.
// Defining NABP_STATE_CTRL_PERF_EN builds the itr/stall perf counters.
module nabp_multi_bank_state_control
    import nabp_state_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int SH_ACCU_W = 16,
    parameter int MP_INIT_W = 16,
    parameter int MP_BASE_W = 16,
    localparam int BANK_W   = bank_w(NUM_BANKS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [SH_ACCU_W-1:0]           sw_sh_accu_base,
    input  logic [MP_INIT_W-1:0]           sw_mp_accu_init,
    input  logic [MP_BASE_W-1:0]           sw_mp_accu_base,
    input  logic                           sw_next_itr_ack,
    input  logic                           sw_swap_ack,
    input  logic [NUM_BANKS-1:0]           sh_fill_done,
    input  logic [NUM_BANKS-1:0]           sh_shift_done,
    output logic                           sw_next_itr,
    output logic                           sw_swap,
    output logic                           sw_pe_en,
    output logic [BANK_W-1:0]              sw_bank_sel,
    output logic [NUM_BANKS-1:0]           sh_fill_kick,
    output logic [NUM_BANKS-1:0]           sh_shift_kick,
    output logic [NUM_BANKS*SH_ACCU_W-1:0] sh_accu_base,
    output logic [MP_INIT_W-1:0]           mp_accu_init,
    output logic [MP_BASE_W-1:0]           mp_accu_base,
    output logic [31:0]                    itr_cnt,
    output logic [31:0]                    stall_cnt
);

    logic [BANK_W-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [BANK_W-1:0]    shift_ptr_q, shift_ptr_d;
    bank_state_e          st [NUM_BANKS];
    logic [MP_INIT_W-1:0] mp_init_b [NUM_BANKS];
    logic [MP_BASE_W-1:0] mp_base_b [NUM_BANKS];
    logic [NUM_BANKS-1:0] alloc_v, swap_v, shdone_v;
    logic                 alloc_fire, swap_fire, shift_fire;

    // sw_next_itr is gated by reset so every output reads 0 while held.
    always_comb begin
        sw_next_itr = reset_n && (st[alloc_ptr_q] == IDLE);
        sw_swap     = (st[shift_ptr_q] == FILLED);
        sw_pe_en    = (st[shift_ptr_q] == SHIFT);
        alloc_fire  = sw_next_itr && sw_next_itr_ack;
        swap_fire   = sw_swap && sw_swap_ack;
        shift_fire  = sw_pe_en && sh_shift_done[shift_ptr_q];
        alloc_v     = '0;
        swap_v      = '0;
        shdone_v    = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            alloc_v[i]  = alloc_fire && (alloc_ptr_q == BANK_W'(i));
            swap_v[i]   = swap_fire && (shift_ptr_q == BANK_W'(i));
            shdone_v[i] = shift_fire && (shift_ptr_q == BANK_W'(i));
        end
        alloc_ptr_d = alloc_ptr_q;
        shift_ptr_d = shift_ptr_q;
        if (alloc_fire)
            alloc_ptr_d = BANK_W'(ptr_wrap(32'(alloc_ptr_q), NUM_BANKS));
        if (shift_fire)
            shift_ptr_d = BANK_W'(ptr_wrap(32'(shift_ptr_q), NUM_BANKS));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_ptr_q <= '0;
            shift_ptr_q <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            shift_ptr_q <= shift_ptr_d;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        nabp_bank_fsm #(
            .SH_ACCU_W(SH_ACCU_W),
            .MP_INIT_W(MP_INIT_W),
            .MP_BASE_W(MP_BASE_W)
        ) u_bank (
            .clk         (clk),
            .reset_n     (reset_n),
            .alloc_i     (alloc_v[g]),
            .sh_base_i   (sw_sh_accu_base),
            .mp_init_i   (sw_mp_accu_init),
            .mp_base_i   (sw_mp_accu_base),
            .fill_done_i (sh_fill_done[g]),
            .swap_i      (swap_v[g]),
            .shift_done_i(shdone_v[g]),
            .state_o     (st[g]),
            .fill_kick_o (sh_fill_kick[g]),
            .shift_kick_o(sh_shift_kick[g]),
            .sh_base_o   (sh_accu_base[g*SH_ACCU_W +: SH_ACCU_W]),
            .mp_init_o   (mp_init_b[g]),
            .mp_base_o   (mp_base_b[g])
        );
    end

    assign sw_bank_sel  = shift_ptr_q;
    assign mp_accu_init = mp_init_b[shift_ptr_q];
    assign mp_accu_base = mp_base_b[shift_ptr_q];

`ifdef NABP_STATE_CTRL_PERF_EN
    logic [31:0] itr_cnt_q, itr_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        itr_cnt_d   = itr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (shift_fire && (itr_cnt_q != '1))
            itr_cnt_d = itr_cnt_q + 32'd1;
        if (sw_swap && !sw_swap_ack && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            itr_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            itr_cnt_q   <= itr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign itr_cnt   = itr_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign itr_cnt   = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nabp_multi_bank_state_control.sv
// Bench for nabp_multi_bank_state_control with NUM_BANKS=2.
module tb_nabp_multi_bank_state_control;

    localparam int N = 2;
`ifdef NABP_STATE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [15:0] sw_sh_accu_base;
    logic [15:0] sw_mp_accu_init;
    logic [15:0] sw_mp_accu_base;
    logic        sw_next_itr_ack;
    logic        sw_swap_ack;
    logic [1:0]  sh_fill_done;
    logic [1:0]  sh_shift_done;
    logic        sw_next_itr;
    logic        sw_swap;
    logic        sw_pe_en;
    logic [0:0]  sw_bank_sel;
    logic [1:0]  sh_fill_kick;
    logic [1:0]  sh_shift_kick;
    logic [31:0] sh_accu_base;
    logic [15:0] mp_accu_init;
    logic [15:0] mp_accu_base;
    logic [31:0] itr_cnt;
    logic [31:0] stall_cnt;

    nabp_multi_bank_state_control #(
        .NUM_BANKS(N), .SH_ACCU_W(16), .MP_INIT_W(16), .MP_BASE_W(16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sw_sh_accu_base(sw_sh_accu_base),
        .sw_mp_accu_init(sw_mp_accu_init),
        .sw_mp_accu_base(sw_mp_accu_base),
        .sw_next_itr_ack(sw_next_itr_ack),
        .sw_swap_ack    (sw_swap_ack),
        .sh_fill_done   (sh_fill_done),
        .sh_shift_done  (sh_shift_done),
        .sw_next_itr    (sw_next_itr),
        .sw_swap        (sw_swap),
        .sw_pe_en       (sw_pe_en),
        .sw_bank_sel    (sw_bank_sel),
        .sh_fill_kick   (sh_fill_kick),
        .sh_shift_kick  (sh_shift_kick),
        .sh_accu_base   (sh_accu_base),
        .mp_accu_init   (mp_accu_init),
        .mp_accu_base   (mp_accu_base),
        .itr_cnt        (itr_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic nxt, input logic swp,
                           input logic pe, input logic sel,
                           input logic [1:0] fk, input logic [1:0] sk,
                           input logic [31:0] sh, input logic [15:0] mi,
                           input logic [15:0] mb);
        chk({t, ".next_itr"}, 64'(sw_next_itr), 64'(nxt));
        chk({t, ".swap"}, 64'(sw_swap), 64'(swp));
        chk({t, ".pe_en"}, 64'(sw_pe_en), 64'(pe));
        chk({t, ".bank_sel"}, 64'(sw_bank_sel), 64'(sel));
        chk({t, ".fill_kick"}, 64'(sh_fill_kick), 64'(fk));
        chk({t, ".shift_kick"}, 64'(sh_shift_kick), 64'(sk));
        chk({t, ".sh_base"}, 64'(sh_accu_base), 64'(sh));
        chk({t, ".mp_init"}, 64'(mp_accu_init), 64'(mi));
        chk({t, ".mp_base"}, 64'(mp_accu_base), 64'(mb));
    endtask

    task automatic idle_in();
        sw_next_itr_ack = 1'b0;
        sw_swap_ack     = 1'b0;
        sh_fill_done    = '0;
        sh_shift_done   = '0;
        sw_sh_accu_base = 16'hDEAD;
        sw_mp_accu_init = 16'hBEEF;
        sw_mp_accu_base = 16'hF00D;
    endtask

    task automatic do_reset();
        idle_in();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        ack, sack;
        logic [1:0]  fd, sd;
        logic [15:0] b, i, m;
        logic        e_nxt, e_sw, e_pe, e_sel;
        logic [1:0]  e_fk, e_sk;
        logic [31:0] e_sh;
        logic [15:0] e_mi, e_mb;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic ack, input logic sack, input logic [1:0] fd,
        input logic [1:0] sd, input logic [15:0] b, input logic [15:0] i,
        input logic [15:0] m, input logic enx, input logic esw,
        input logic epe, input logic esel, input logic [1:0] efk,
        input logic [1:0] esk, input logic [31:0] esh,
        input logic [15:0] emi, input logic [15:0] emb);
        vec_t v;
        v.ack = ack; v.sack = sack; v.fd = fd; v.sd = sd;
        v.b = b; v.i = i; v.m = m;
        v.e_nxt = enx; v.e_sw = esw; v.e_pe = epe; v.e_sel = esel;
        v.e_fk = efk; v.e_sk = esk; v.e_sh = esh;
        v.e_mi = emi; v.e_mb = emb;
        tbl.push_back(v);
    endfunction

    // Reference model: each bank is free, loading, ready or running;
    // ready banks run strictly in the order they were handed out.
    typedef enum {M_FREE, M_LOADING, M_READY, M_RUNNING} mstate_e;
    mstate_e     mst [N];
    int          ma, ms;
    logic [15:0] mbase [N];
    logic [15:0] minit [N];
    logic [15:0] mmpb [N];
    logic [1:0]  mfk, msk;
    longint      m_itr, m_stall;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mst[k] = M_FREE; mbase[k] = 0; minit[k] = 0; mmpb[k] = 0;
        end
        ma = 0; ms = 0; mfk = 0; msk = 0; m_itr = 0; m_stall = 0;
    endtask

    task automatic model_step();
        bit alloc, swapg, done;
        bit [1:0] fills;
        alloc = (mst[ma] == M_FREE) && sw_next_itr_ack;
        swapg = (mst[ms] == M_READY) && sw_swap_ack;
        done  = (mst[ms] == M_RUNNING) && sh_shift_done[ms];
        for (int k = 0; k < N; k++)
            fills[k] = (mst[k] == M_LOADING) && sh_fill_done[k];
        if (mst[ms] == M_READY && !sw_swap_ack) m_stall++;
        mfk = 0; msk = 0;
        for (int k = 0; k < N; k++)
            if (fills[k]) mst[k] = M_READY;
        if (alloc) begin
            mst[ma] = M_LOADING;
            mbase[ma] = sw_sh_accu_base;
            minit[ma] = sw_mp_accu_init;
            mmpb[ma]  = sw_mp_accu_base;
            mfk[ma] = 1'b1;
            ma = (ma + 1) % N;
        end
        if (swapg) begin
            mst[ms] = M_RUNNING;
            msk[ms] = 1'b1;
        end
        if (done) begin
            mst[ms] = M_FREE;
            m_itr++;
            ms = (ms + 1) % N;
        end
    endtask

    task automatic model_chk();
        chk_all("rand", mst[ma] == M_FREE, mst[ms] == M_READY,
                mst[ms] == M_RUNNING, 1'(ms), mfk, msk,
                {mbase[1], mbase[0]}, minit[ms], mmpb[ms]);
        chk("rand.itr_cnt", 64'(itr_cnt), PERF ? 64'(m_itr) : 64'd0);
        chk("rand.stall_cnt", 64'(stall_cnt), PERF ? 64'(m_stall) : 64'd0);
    endtask

    logic [15:0] D;
    logic [31:0] exp_st, exp_it;

    initial begin
        D = 16'hDEAD;
        reset_n = 1'b0;
        idle_in();

        // ack  sack fd    sd     base     init     mpb  | nxt sw pe sel fk sk sh mi mb
        add(1, 0, 2'b00, 2'b00, 16'h0A0A, 16'h1111, 16'h2222,
            1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 16'h0, 16'h0);
        add(1, 0, 2'b00, 2'b00, 16'h0B0B, 16'h3333, 16'h4444,
            1, 0, 0, 0, 2'b01, 2'b00, 32'h00000A0A, 16'h1111, 16'h2222);
        add(0, 0, 2'b01, 2'b10, D, D, D,
            0, 0, 0, 0, 2'b10, 2'b00, 32'h0B0B0A0A, 16'h1111, 16'h2222);
        add(0, 1, 2'b00, 2'b00, D, D, D,
            0, 1, 0, 0, 2'b00, 2'b00, 32'h0B0B0A0A, 16'h1111, 16'h2222);
        add(0, 0, 2'b10, 2'b00, D, D, D,
            0, 0, 1, 0, 2'b00, 2'b01, 32'h0B0B0A0A, 16'h1111, 16'h2222);
        add(0, 0, 2'b00, 2'b01, D, D, D,
            0, 0, 1, 0, 2'b00, 2'b00, 32'h0B0B0A0A, 16'h1111, 16'h2222);
        add(0, 1, 2'b00, 2'b00, D, D, D,
            1, 1, 0, 1, 2'b00, 2'b00, 32'h0B0B0A0A, 16'h3333, 16'h4444);
        add(0, 0, 2'b00, 2'b00, D, D, D,
            1, 0, 1, 1, 2'b00, 2'b10, 32'h0B0B0A0A, 16'h3333, 16'h4444);
        add(1, 0, 2'b00, 2'b00, 16'h0C0C, 16'h5555, 16'h6666,
            1, 0, 1, 1, 2'b00, 2'b00, 32'h0B0B0A0A, 16'h3333, 16'h4444);
        add(1, 0, 2'b00, 2'b00, 16'h0DDD, 16'h7777, 16'h8888,
            0, 0, 1, 1, 2'b01, 2'b00, 32'h0B0B0C0C, 16'h3333, 16'h4444);
        add(0, 0, 2'b00, 2'b10, D, D, D,
            0, 0, 1, 1, 2'b00, 2'b00, 32'h0B0B0C0C, 16'h3333, 16'h4444);
        add(1, 0, 2'b00, 2'b00, 16'h0E0E, 16'h9999, 16'hAAAA,
            1, 0, 0, 0, 2'b00, 2'b00, 32'h0B0B0C0C, 16'h5555, 16'h6666);
        add(0, 0, 2'b10, 2'b00, D, D, D,
            0, 0, 0, 0, 2'b10, 2'b00, 32'h0E0E0C0C, 16'h5555, 16'h6666);
        add(0, 0, 2'b01, 2'b01, D, D, D,
            0, 0, 0, 0, 2'b00, 2'b00, 32'h0E0E0C0C, 16'h5555, 16'h6666);
        add(0, 1, 2'b00, 2'b00, D, D, D,
            0, 1, 0, 0, 2'b00, 2'b00, 32'h0E0E0C0C, 16'h5555, 16'h6666);
        add(0, 0, 2'b00, 2'b01, D, D, D,
            0, 0, 1, 0, 2'b00, 2'b01, 32'h0E0E0C0C, 16'h5555, 16'h6666);
        add(0, 1, 2'b00, 2'b00, D, D, D,
            1, 1, 0, 1, 2'b00, 2'b00, 32'h0E0E0C0C, 16'h9999, 16'hAAAA);
        add(0, 0, 2'b00, 2'b10, D, D, D,
            1, 0, 1, 1, 2'b00, 2'b10, 32'h0E0E0C0C, 16'h9999, 16'hAAAA);
        add(0, 0, 2'b00, 2'b00, D, D, D,
            1, 0, 0, 0, 2'b00, 2'b00, 32'h0E0E0C0C, 16'h5555, 16'h6666);

        // Directed table: alloc, overlap, in-order shift, full, wrap.
        do_reset();
        foreach (tbl[k]) begin
            #1;
            chk_all($sformatf("tbl%0d", k), tbl[k].e_nxt, tbl[k].e_sw,
                    tbl[k].e_pe, tbl[k].e_sel, tbl[k].e_fk, tbl[k].e_sk,
                    tbl[k].e_sh, tbl[k].e_mi, tbl[k].e_mb);
            sw_next_itr_ack = tbl[k].ack;
            sw_swap_ack     = tbl[k].sack;
            sh_fill_done    = tbl[k].fd;
            sh_shift_done   = tbl[k].sd;
            sw_sh_accu_base = tbl[k].b;
            sw_mp_accu_init = tbl[k].i;
            sw_mp_accu_base = tbl[k].m;
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a shift.
        do_reset();
        #1;
        sw_next_itr_ack = 1'b1;
        sw_sh_accu_base = 16'h1234;
        @(negedge clk);
        #1;
        idle_in();
        sh_fill_done = 2'b01;
        @(negedge clk);
        #1;
        idle_in();
        sw_swap_ack = 1'b1;
        @(negedge clk);
        #1;
        idle_in();
        chk("rst.pe_before", 64'(sw_pe_en), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                32'h0, 16'h0, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_all("rst.release", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                32'h0, 16'h0, 16'h0);
        sw_next_itr_ack = 1'b1;
        sw_sh_accu_base = 16'h5A5A;
        @(negedge clk);
        #1;
        idle_in();
        chk("rst.alloc_ptr0", 64'(sh_fill_kick), 64'd1);
        chk("rst.base0", 64'(sh_accu_base), 64'h5A5A);

        // Swap ack withheld for five cycles, then one full shift.
        do_reset();
        #1;
        sw_next_itr_ack = 1'b1;
        @(negedge clk);
        #1;
        idle_in();
        sh_fill_done = 2'b01;
        @(negedge clk);
        #1;
        idle_in();
        repeat (5) @(negedge clk);
        #1;
        exp_st = PERF ? 32'd5 : 32'd0;
        chk("perf.swap_held", 64'(sw_swap), 64'd1);
        chk("perf.stall5", 64'(stall_cnt), 64'(exp_st));
        sw_swap_ack = 1'b1;
        @(negedge clk);
        #1;
        idle_in();
        sh_shift_done = 2'b01;
        @(negedge clk);
        #1;
        idle_in();
        exp_it = PERF ? 32'd1 : 32'd0;
        chk("perf.itr1", 64'(itr_cnt), 64'(exp_it));
        chk("perf.stall_hold", 64'(stall_cnt), 64'(exp_st));

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            #1;
            model_chk();
            sw_next_itr_ack = ($urandom_range(0, 1) == 1);
            sw_swap_ack     = ($urandom_range(0, 9) < 4);
            sh_fill_done[0] = ($urandom_range(0, 9) < 3);
            sh_fill_done[1] = ($urandom_range(0, 9) < 3);
            sh_shift_done[0] = ($urandom_range(0, 9) < 3);
            sh_shift_done[1] = ($urandom_range(0, 9) < 3);
            sw_sh_accu_base = 16'($urandom);
            sw_mp_accu_init = 16'($urandom);
            sw_mp_accu_base = 16'($urandom);
            model_step();
            @(negedge clk);
        end
        #1;
        model_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
